// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester register file write arbiter with registered write port
// Optional round-robin conflict resolution under WARB_ROUND_ROBIN_EN; otherwise load return (B) always wins.
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              hold,
  output logic              Reg_Write,
  output logic [ADDR_W-1:0] Write_Reg,
  output logic [DATA_W-1:0] Write_Data,
  input  logic [ADDR_W-1:0] q_reg,
  output logic              q_pending,
  output logic [15:0]       wr_count
);

  logic              a_wins;
  logic              open;
  logic              accept;
  logic              real_write;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

`ifdef WARB_ROUND_ROBIN_EN
  localparam logic PREF_A = 1'b0;
  localparam logic PREF_B = 1'b1;

  logic ptr;

  assign a_wins = (ptr == PREF_A);

  // Pointer only moves on a real conflict so a lone requester never skews fairness.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PREF_A;
    end else if (!hold && a_valid && b_valid) begin
      ptr <= (ptr == PREF_A) ? PREF_B : PREF_A;
    end
  end
`else
  assign a_wins = 1'b0;
`endif

  assign open    = !reset && !hold;
  assign a_ready = open && a_valid && (!b_valid || a_wins);
  assign b_ready = open && b_valid && (!a_valid || !a_wins);

  assign accept     = a_ready || b_ready;
  assign sel_reg    = a_ready ? a_reg  : b_reg;
  assign sel_data   = a_ready ? a_data : b_data;
  // Register 0 is hardwired; its writes are drained but never reach the file.
  assign real_write = accept && (sel_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      Reg_Write  <= 1'b0;
      Write_Reg  <= '0;
      Write_Data <= '0;
      wr_count   <= 16'h0000;
    end else if (!hold) begin
      Reg_Write <= real_write;
      if (real_write) begin
        Write_Reg  <= sel_reg;
        Write_Data <= sel_data;
        if (wr_count != 16'hFFFF) begin
          wr_count <= wr_count + 16'h0001;
        end
      end
    end
  end

  assign q_pending = Reg_Write && (Write_Reg == q_reg) && (q_reg != '0);

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, data width of each write.
REQ-002 Parameter: ADDR_W, 5, register index width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: a_valid / a_ready / a_reg / a_data  in/out/in/in  1/1/ADDR_W/DATA_W  requester A (ALU writeback) channel.
REQ-006 Port: b_valid / b_ready / b_reg / b_data  in/out/in/in  1/1/ADDR_W/DATA_W  requester B (load return) channel.
REQ-007 Port: hold  input  1  register file write port unavailable; freezes output stage.
REQ-008 Port: Reg_Write / Write_Reg / Write_Data  out/out/out  1/ADDR_W/DATA_W  registered drive to register file write port.
REQ-009 Port: q_reg  input  ADDR_W  hazard query index.
REQ-010 Port: q_pending  output  1  combinational; 1 when the output stage holds a valid write to q_reg.
REQ-011 Port: wr_count  output  16  saturating count of writes issued to the register file.

Function
REQ-012 A transfer on a channel SHALL occur in a cycle where valid and ready are both 1; a requester SHALL hold reg/data stable while valid=1 and ready=0.
REQ-013 When hold=1, a_ready and b_ready SHALL be 0 and Reg_Write, Write_Reg, Write_Data, wr_count SHALL keep their values.
REQ-014 When hold=0, at most one ready SHALL be 1: the sole valid requester, or the arbitration winner when both are valid; neither ready when neither is valid.
REQ-015 An accepted write SHALL appear on Reg_Write/Write_Reg/Write_Data on the next rising edge (latency 1) and remain for exactly one cycle unless hold=1 is then asserted.
REQ-016 Cycles with hold=0 and no acceptance SHALL load Reg_Write=0; Write_Reg and Write_Data SHALL then keep their previous values.
REQ-017 An accepted write with reg index 0 SHALL be consumed (ready=1) but SHALL produce Reg_Write=0 and SHALL NOT increment wr_count.
REQ-018 wr_count SHALL increment by 1 at each edge that loads Reg_Write=1, saturating at 16'hFFFF.
REQ-019 q_pending SHALL equal Reg_Write AND (Write_Reg == q_reg) AND (q_reg != 0).
REQ-020 State machine (arbitration pointer) states: PREF_A, PREF_B; in PREF_A A wins a conflict, in PREF_B B wins.
REQ-021 The pointer SHALL move to the state favouring the loser only in a cycle where both requesters are valid and hold=0; otherwise it SHALL not change.

Reset
REQ-022 At a rising edge with reset=1: Reg_Write=0, Write_Reg=0, Write_Data=0, wr_count=0, pointer=PREF_A; reset overrides hold and any in-flight acceptance.
REQ-023 While reset=1, a_ready and b_ready SHALL be 0; a write accepted in the cycle reset asserts SHALL be discarded.

Configuration
REQ-024 Macro WARB_ROUND_ROBIN_EN defined: pointer behaves per REQ-020/021.
REQ-025 Macro WARB_ROUND_ROBIN_EN undefined: pointer logic absent; B (load return) SHALL always win a conflict; all other behaviour identical.

Verification
REQ-026 Reset, then a_valid=1 a_reg=3 a_data=32'h11 one cycle -> next cycle Reg_Write=1 Write_Reg=3 Write_Data=32'h11, wr_count=1; following cycle Reg_Write=0.
REQ-027 Both valid for 4 cycles (A reg 4, B reg 5, RR enabled) -> grants A,B,A,B; Write_Reg sequence 4,5,4,5; wr_count=4.
REQ-028 Same stimulus, WARB_ROUND_ROBIN_EN undefined -> B granted all 4 cycles, A stalled with a_ready=0 throughout.
REQ-029 A write to reg 7 accepted, hold=1 asserted next cycle for 3 cycles with q_reg=7 -> Reg_Write stays 1, q_pending=1, both readies 0, wr_count unchanged until hold drops.
REQ-030 b_valid=1 b_reg=0 b_data=32'hFF -> b_ready=1, next cycle Reg_Write=0, wr_count unchanged; reset asserted mid-stream with hold=1 -> all outputs 0 next edge.
